// File: rtl/hv_dac_spi_rx.sv
// hv_dac_spi_rx: serial receiver for an 8-channel, 10-bit high-voltage DAC
// register file. Frames are 16 bits, MSB first, framed by dac_cs low:
//   [15:12] address (2..9 -> channel 0..7, 0 -> NOP), [11:2] value, [1:0] pad.
// Optional feature: define HV_DAC_RX_ERRCNT_EN to enable the saturating
// 8-bit error counter on err_cnt; otherwise err_cnt is tied to zero.
module hv_dac_spi_rx (
  input  logic        sclk,
  input  logic        reset,
  input  logic        dac_cs,
  input  logic        dac_din,
  output logic [79:0] hv_regs,
  output logic        word_valid,
  output logic [2:0]  word_ch,
  output logic        frame_err,
  output logic        addr_err,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  bitcnt;
  logic [15:0] shreg;
  logic        overrun;
  // Set by reset: a frame already running when reset releases is ignored
  // until dac_cs has been seen high once.
  logic        resync;

  logic        start;
  logic        wr;
  logic        ferr;
  logic        aerr;
  logic [3:0]  addr;
  logic [2:0]  wr_ch;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge sclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and commit decode of the assembled word.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    wr        = 1'b0;
    ferr      = 1'b0;
    aerr      = 1'b0;
    addr      = shreg[15:12];
    // addr 2..9 maps to channel 0..7; modulo-8 subtraction covers 8 and 9.
    wr_ch     = addr[2:0] - 3'd2;
    case (state)
      IDLE: begin
        if (!dac_cs && !resync) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (dac_cs) begin
          ferr      = 1'b1;
          state_nxt = IDLE;
        end else if (bitcnt == 5'd15) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (dac_cs) begin
          state_nxt = IDLE;
          if (overrun)                         ferr = 1'b1;
          else if (addr == 4'd0)               ; // NOP, pad bits ignored
          else if (addr >= 4'd2 && addr <= 4'd9 && shreg[1:0] == 2'b00)
                                               wr   = 1'b1;
          else                                 aerr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter, overrun tracking and registered outputs.
  always_ff @(posedge sclk) begin
    if (reset) begin
      bitcnt     <= '0;
      shreg      <= '0;
      overrun    <= 1'b0;
      resync     <= 1'b1;
      hv_regs    <= '0;
      word_ch    <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      word_valid <= wr;
      frame_err  <= ferr;
      addr_err   <= aerr;
      if (dac_cs) resync <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg  <= {15'b0, dac_din};
            bitcnt <= 5'd1;
          end
        end
        SHIFT: begin
          if (dac_cs) begin
            bitcnt <= '0;
          end else begin
            shreg  <= {shreg[14:0], dac_din};
            bitcnt <= bitcnt + 5'd1;
          end
        end
        FULL: begin
          if (dac_cs) begin
            overrun <= 1'b0;
            bitcnt  <= '0;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase
      if (wr) word_ch <= wr_ch;
      for (int unsigned n = 0; n < 8; n++) begin
        if (wr && wr_ch == 3'(n)) hv_regs[n*10 +: 10] <= shreg[11:2];
      end
    end
  end

`ifdef HV_DAC_RX_ERRCNT_EN
  logic [7:0] err_q;

  // Saturating count of frame and address errors, in step with the pulses.
  always_ff @(posedge sclk) begin
    if (reset)                          err_q <= '0;
    else if ((ferr || aerr) && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hv_dac_spi_rx.sv
// Self-checking bench for hv_dac_spi_rx: directed table, hand-written reset
// sequence, error-counter saturation and randomized frames against a
// word-level reference model. Honours HV_DAC_RX_ERRCNT_EN like the design.
module tb_hv_dac_spi_rx;

  logic        sclk;
  logic        reset;
  logic        dac_cs;
  logic        dac_din;
  logic [79:0] hv_regs;
  logic        word_valid;
  logic [2:0]  word_ch;
  logic        frame_err;
  logic        addr_err;
  logic        busy;
  logic [7:0]  err_cnt;

  hv_dac_spi_rx dut (
    .sclk       (sclk),
    .reset      (reset),
    .dac_cs     (dac_cs),
    .dac_din    (dac_din),
    .hv_regs    (hv_regs),
    .word_valid (word_valid),
    .word_ch    (word_ch),
    .frame_err  (frame_err),
    .addr_err   (addr_err),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: channel values, last channel, error count.
  logic [9:0]  m_regs [8];
  logic [2:0]  m_ch;
  int unsigned m_err;

  // Pulse accounting: every pulse seen vs. every pulse predicted.
  int unsigned pulse_seen = 0;
  int unsigned pulse_exp  = 0;
  int unsigned multi_seen = 0;
  logic        mon_en     = 1'b0;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_WV   = 3'b001;
  localparam logic [2:0] K_FE   = 3'b010;
  localparam logic [2:0] K_AE   = 3'b100;

  typedef struct {
    logic [15:0] w;
    int unsigned len;
    logic [2:0]  kind;
  } vec_t;

  vec_t tbl [8];

  always @(negedge sclk) begin
    if (mon_en) begin
      pulse_seen += int'(word_valid) + int'(frame_err) + int'(addr_err);
      if (int'(word_valid) + int'(frame_err) + int'(addr_err) > 1) multi_seen++;
    end
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int unsigned n = 0; n < 8; n++) m_regs[n] = '0;
    m_ch  = '0;
    m_err = 0;
  endtask

  task automatic model_err();
`ifdef HV_DAC_RX_ERRCNT_EN
    if (m_err < 255) m_err++;
`endif
  endtask

  // Outcome of a frame of `len` bits whose first 16 bits form `w`.
  task automatic model_frame(input logic [15:0] w, input int unsigned len, output logic [2:0] kind);
    int unsigned a;
    a = int'(w[15:12]);
    if (len != 16) begin
      model_err();
      kind = K_FE;
    end else if (a == 0) begin
      kind = K_NONE;
    end else if (a >= 2 && a <= 9 && w[1:0] == 2'b00) begin
      m_regs[a-2] = w[11:2];
      m_ch        = 3'(a - 2);
      kind        = K_WV;
    end else begin
      model_err();
      kind = K_AE;
    end
  endtask

  function automatic logic [79:0] model_regs();
    logic [79:0] v;
    for (int unsigned n = 0; n < 8; n++) v[n*10 +: 10] = m_regs[n];
    return v;
  endfunction

  // Send one frame, then check the pulse, register file, channel and counter
  // one cycle after the edge that samples dac_cs high.
  task automatic run_frame(input logic [15:0] w, input int unsigned len, input int unsigned gap,
                           input logic [2:0] kind_tbl, input logic use_tbl);
    logic [2:0] kind_m;
    logic [2:0] obs;
    for (int unsigned i = 0; i < len; i++) begin
      @(negedge sclk);
      dac_cs = 1'b0;
      if (i < 16) dac_din = w[15-i];
      else        dac_din = 1'($urandom_range(0, 1));
      if (i == 1) check("busy_in_frame", 80'(busy), 80'(1));
    end
    @(negedge sclk);
    dac_cs  = 1'b1;
    dac_din = 1'b0;
    @(posedge sclk);
    #1;
    model_frame(w, len, kind_m);
    pulse_exp += int'(kind_m[0]) + int'(kind_m[1]) + int'(kind_m[2]);
    obs = {addr_err, frame_err, word_valid};
    check("pulse_vs_model", 80'(obs), 80'(kind_m));
    if (use_tbl) check("pulse_vs_table", 80'(obs), 80'(kind_tbl));
    check("hv_regs", hv_regs, model_regs());
    check("word_ch", 80'(word_ch), 80'(m_ch));
    check("err_cnt", 80'(err_cnt), 80'(m_err));
    check("busy_after", 80'(busy), 80'(0));
    for (int unsigned g = 1; g < gap; g++) @(negedge sclk);
  endtask

  initial begin
    logic [15:0] w;
    int unsigned len;
    int unsigned r;

    tbl[0] = '{16'h2554, 16, K_WV};
    tbl[1] = '{16'h9FFC, 16, K_WV};
    tbl[2] = '{16'h3004, 16, K_WV};
    tbl[3] = '{16'h5000, 10, K_FE};
    tbl[4] = '{16'h5000, 17, K_FE};
    tbl[5] = '{16'hA000, 16, K_AE};
    tbl[6] = '{16'h2001, 16, K_AE};
    tbl[7] = '{16'h00FF, 16, K_NONE};

    reset   = 1'b1;
    dac_cs  = 1'b1;
    dac_din = 1'b0;
    model_reset();
    repeat (3) @(negedge sclk);
    check("reset_hv_regs", hv_regs, 80'(0));
    check("reset_outs", 80'({word_valid, frame_err, addr_err, busy, word_ch}), 80'(0));
    check("reset_err_cnt", 80'(err_cnt), 80'(0));
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge sclk);

    // Directed table.
    for (int unsigned i = 0; i < 8; i++) begin
      run_frame(tbl[i].w, tbl[i].len, 1, tbl[i].kind, 1'b1);
      if (i == 2) begin
        check("ch7_3FF", 80'(hv_regs[79:70]), 80'(10'h3FF));
        check("ch1_001", 80'(hv_regs[19:10]), 80'(10'h001));
        check("ch0_155", 80'(hv_regs[9:0]), 80'(10'h155));
      end
`ifdef HV_DAC_RX_ERRCNT_EN
      if (i == 4) check("err_cnt_two", 80'(err_cnt), 80'(2));
`else
      if (i == 4) check("err_cnt_off", 80'(err_cnt), 80'(0));
`endif
    end
    check("word_ch_last", 80'(word_ch), 80'(3'd1));

    // Reset at bit 8 of 16'h4AAC; remaining bits arrive with dac_cs low.
    w = 16'h4AAC;
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge sclk);
      dac_cs  = 1'b0;
      dac_din = w[15-i];
      reset   = (i == 8);
    end
    @(negedge sclk);
    dac_cs = 1'b1;
    model_reset();
    @(posedge sclk);
    #1;
    check("rst_no_pulse", 80'({addr_err, frame_err, word_valid}), 80'(0));
    check("rst_hv_regs", hv_regs, 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    run_frame(16'h4AAC, 16, 1, K_WV, 1'b1);
    check("ch2_2AB", 80'(hv_regs[29:20]), 80'(10'h2AB));

    // 300 short frames drive the counter to saturation.
    for (int unsigned i = 0; i < 300; i++) run_frame(16'($urandom), 3, 1, K_FE, 1'b1);
`ifdef HV_DAC_RX_ERRCNT_EN
    check("err_cnt_sat", 80'(err_cnt), 80'(8'hFF));
    run_frame(16'hF000, 16, 2, K_AE, 1'b1);
    check("err_cnt_hold", 80'(err_cnt), 80'(8'hFF));
`else
    check("err_cnt_zero", 80'(err_cnt), 80'(0));
`endif

    // Randomized frames; reset first so the counter is visible again.
    @(negedge sclk);
    reset = 1'b1;
    @(negedge sclk);
    reset = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 300; i++) begin
      w = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       w[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(1, 15);
      else if (r == 1) len = $urandom_range(17, 20);
      else             len = 16;
      run_frame(w, len, $urandom_range(1, 3), K_NONE, 1'b0);
    end

    repeat (3) @(negedge sclk);
    check("pulse_total", 80'(pulse_seen), 80'(pulse_exp));
    check("multi_pulse", 80'(multi_seen), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
